mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage initiator driving the word-addressed data memory: turns pipeline load/store requests into memory read/write strobes.
- Supports byte/halfword/word sizes and sign/zero extension; sub-word stores use read-modify-write.
- Stalls the pipeline until each access completes.

Parameters:
- ADDR_W, 6, word-index width of data memory (depth 2**ADDR_W words)
- DATA_W, 32, memory word width; fixed at 32 (byte-lane logic assumes 4 lanes)

Ports:
- Clock  in  1  single clock, all state updates on posedge
- Reset  in  1  synchronous, active-high
- ReqValid  in  1  pipeline presents a memory op this cycle
- ReqStore  in  1  1=store, 0=load
- ReqSize  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
- ReqSigned  in  1  loads: 1=sign-extend, 0=zero-extend
- ReqAddress  in  32  byte address
- ReqStoreData  in  32  store data, right-aligned
- LoadData  out  32  extended load result, valid when Done & load
- Done  out  1  access completes this cycle
- Stall  out  1  pipeline must hold
- Misaligned  out  1  one-cycle pulse; request rejected
- MemAddress  out  ADDR_W  word index to memory
- MemWriteData  out  32  word to memory
- MemoryRead  out  1  read strobe; memory captures at the next posedge
- MemoryWrite  out  1  write strobe; memory writes at the falling edge of the same cycle
- MemReadData  in  32  registered memory output, valid the cycle after MemoryRead

Behaviour:
- Reset values:
  - state IDLE
  - LoadData=0, MemAddress=0, MemWriteData=0
  - MemoryRead, MemoryWrite, Done, Stall, Misaligned all 0
- Word index = ReqAddress[ADDR_W+1:2]; upper address bits ignored (wrap).
- Lane k = ReqAddress[1:0], little-endian: byte k = bits [8k+7:8k].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
  - On a violation in IDLE: Misaligned=1 that cycle, Stall=0, no strobes, no state change.
- Request latching: address, size, signedness, store flag and data are latched on acceptance. Inputs are don't-care afterwards.
- Moore FSM; strobes and Done are decoded from state.
  - IDLE: accept when ReqValid & aligned. Word store -> WRITE; load or sub-word store -> READ.
  - READ: MemoryRead=1 -> WAIT.
  - WAIT: MemReadData valid.
    - Load: LoadData = selected lane extended per ReqSigned; Done=1 -> IDLE.
    - Sub-word store: merge store byte/half into the read word at lane k, register into MemWriteData -> WRITE.
  - WRITE: MemoryWrite=1, Done=1 -> IDLE.
- Latency from the accept cycle T:
  - word store: Done at T+1
  - load: Done at T+2
  - sub-word store: Done at T+3
- Stall = (IDLE & ReqValid & aligned) | (state not IDLE & ~Done).
- Done is a one-cycle pulse. The next request is accepted only in IDLE, giving a minimum 1-cycle gap between ops.
- LoadData holds its last value until the next load completes.
- Reset mid-op:
  - FSM returns to IDLE at the reset posedge; no Done is issued.
  - A WRITE cycle in flight when Reset is sampled has already written at the falling edge; the write completes.
  - Reset during READ/WAIT aborts the op with no memory side effect.
- Reserved size 11 behaves exactly as word.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encodings
  - DATA_W
- One sub-module, lane_align: combinational lane extract+extend for loads and lane merge for stores.

Test Plan:
- Word store 0xDEADBEEF @ 0x10, then word load @ 0x10 -> MemoryWrite at T+1 with MemAddress=4; load Done at T+2, LoadData=0xDEADBEEF.
- Memory word 0x80FF7F01 @ 0x20; byte loads at 0x21 signed / 0x23 unsigned / 0x23 signed -> 0x0000007F, 0x00000080, 0xFFFFFF80.
- Byte store 0xAB @ 0x22 over 0x11223344 -> READ, WAIT, WRITE with MemWriteData=0x11AB3344; Done at T+3; Stall high T..T+2.
- Half load @ 0x03 -> Misaligned pulse, Stall=0, no strobes; following aligned request is accepted normally.
- Reset asserted in WAIT of a sub-word store -> no MemoryWrite, IDLE next cycle, memory unchanged; reset asserted in WRITE -> write is visible on a subsequent load.
- Address 0x104 word load -> MemAddress=1 (wrap).

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: size codes, FSM states and
// the alignment rule used when a request is presented.
package mem_access_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    // Reserved size 2'b11 falls into the word rule.
    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: size_aligned = 1'b1;
            SZ_HALF: size_aligned = ~lane[0];
            default: size_aligned = (lane == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extract+extend a byte/half for loads, and merge a
// byte/half into a read word for sub-word stores.
module lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] sdata,
    output logic [DATA_W-1:0] load_ext,
    output logic [DATA_W-1:0] merged
);

    function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic s);
        logic signed [7:0] bs;
        bs = b;
        ext_byte = s ? DATA_W'(bs) : DATA_W'(b);
    endfunction

    function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic s);
        logic signed [15:0] hs;
        hs = h;
        ext_half = s ? DATA_W'(hs) : DATA_W'(h);
    endfunction

    logic [4:0]        shamt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;

    always_comb begin
        shamt    = {lane, 3'b000};
        shifted  = rdata >> shamt;
        load_ext = rdata;
        mask     = '1;
        case (size)
            SZ_BYTE: begin
                load_ext = ext_byte(shifted[7:0], sgn);
                mask     = DATA_W'(32'h0000_00FF) << shamt;
            end
            SZ_HALF: begin
                load_ext = ext_half(shifted[15:0], sgn);
                mask     = DATA_W'(32'h0000_FFFF) << shamt;
            end
            default: ;
        endcase
        merged = (rdata & ~mask) | ((sdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns pipeline load/store requests into read/write strobes
// on a word-addressed memory, using read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    input  logic              ReqStore,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [31:0]       ReqAddress,
    input  logic [31:0]       ReqStoreData,
    output logic [DATA_W-1:0] LoadData,
    output logic              Done,
    output logic              Stall,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemoryRead,
    output logic              MemoryWrite,
    input  logic [DATA_W-1:0] MemReadData
);
    import mem_access_unit_pkg::*;

    state_t            state, state_next;
    logic              aligned;
    logic              accept;
    logic [1:0]        lane_p0;
    logic [1:0]        size_p0;
    logic              signed_p0;
    logic              store_p0;
    logic [DATA_W-1:0] sdata_p0;
    logic [DATA_W-1:0] load_hold;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;
    logic              load_done;
    logic              unused_addr;

    // Upper address bits wrap onto the memory depth.
    assign unused_addr = ^ReqAddress[31:ADDR_W+2];

    assign aligned   = size_aligned(ReqSize, ReqAddress[1:0]);
    assign accept    = (state == ST_IDLE) && ReqValid && aligned;
    assign load_done = (state == ST_WAIT) && !store_p0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        Done        = 1'b0;
        Misaligned  = 1'b0;
        case (state)
            ST_IDLE: begin
                Misaligned = ReqValid && !aligned;
                if (accept) begin
                    state_next = (ReqStore && ReqSize[1]) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                MemoryRead = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                Done       = !store_p0;
                state_next = store_p0 ? ST_WRITE : ST_IDLE;
            end
            ST_WRITE: begin
                MemoryWrite = 1'b1;
                Done        = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        Stall = accept || ((state != ST_IDLE) && !Done);
    end

    // Request capture at acceptance; read data merged or extracted in WAIT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            MemAddress   <= '0;
            MemWriteData <= '0;
            load_hold    <= '0;
        end else begin
            if (accept) begin
                MemAddress <= ReqAddress[ADDR_W+1:2];
                if (ReqStore) begin
                    MemWriteData <= ReqStoreData;
                end
            end
            if (state == ST_WAIT) begin
                if (store_p0) begin
                    MemWriteData <= merged;
                end else begin
                    load_hold <= load_ext;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            lane_p0   <= ReqAddress[1:0];
            size_p0   <= ReqSize;
            signed_p0 <= ReqSigned;
            store_p0  <= ReqStore;
            sdata_p0  <= ReqStoreData;
        end
    end

    lane_align u_lane_align (
        .rdata    (MemReadData),
        .lane     (lane_p0),
        .size     (size_p0),
        .sgn      (signed_p0),
        .sdata    (sdata_p0),
        .load_ext (load_ext),
        .merged   (merged)
    );

    // The extended word is presented in the Done cycle and held afterwards.
    assign LoadData = load_done ? load_ext : load_hold;

endmodule
